// File: rtl/hud_stats_counter.sv
// hud_stats_counter: saturating BCD hit counters per drum, streaming dirty digits to the HUD renderer during vblank
module hud_stats_counter #(
  parameter int NUM_DRUMS    = 4,
  parameter int DIGITS       = 2,
  parameter int VBLANK_START = 768
) (
  input  logic       vclock,
  input  logic       reset,
  input  logic       hit_valid,
  input  logic [3:0] hit_drum,
  input  logic       clear,
  input  logic [9:0] vcount,
  output logic       write,
  output logic [3:0] num,
  output logic [3:0] blob,
  output logic       busy
);
  localparam int DW = NUM_DRUMS > 1 ? $clog2(NUM_DRUMS) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = DIGITS * 4;
  localparam logic [4:0] ND = 5'(NUM_DRUMS);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, WRITE = 2'd2;
  logic [CW-1:0] cnt [NUM_DRUMS];
  logic [CW-1:0] inc_val;
  logic [NUM_DRUMS-1:0] dirty, scan_clr, hit_set;
  logic [1:0] state, state_n;
  logic [DW-1:0] cur_drum, first_dirty, wr_drum, hd;
  logic [IW-1:0] idx, wr_idx;
  logic [3:0] wr_digit;
  logic hit_ok, vblank, carry;
  assign vblank   = vcount >= 10'(VBLANK_START);
  assign hit_ok   = hit_valid && ({1'b0, hit_drum} < ND);
  assign hd       = hit_drum[DW-1:0];
  assign busy     = state != IDLE;
  assign hit_set  = hit_ok ? NUM_DRUMS'(1) << hd : '0;
  assign scan_clr = state == SCAN ? NUM_DRUMS'(1) << first_dirty : '0;
  assign wr_drum  = state == SCAN ? first_dirty : cur_drum;
  assign wr_idx   = state == SCAN ? '0 : idx + IW'(1);
  assign wr_digit = cnt[wr_drum][{wr_idx, 2'b00} +: 4];
  // ripple BCD increment; a carry out of the top digit means all 9s, so hold
  always_comb begin
    inc_val = cnt[hd];
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        inc_val[i*4 +: 4] = cnt[hd][i*4 +: 4] == 4'd9 ? 4'd0 : cnt[hd][i*4 +: 4] + 4'd1;
        carry = cnt[hd][i*4 +: 4] == 4'd9;
      end
    end
    if (carry) inc_val = cnt[hd];
  end
  always_comb begin
    first_dirty = '0;
    for (int i = NUM_DRUMS - 1; i >= 0; i--)
      if (dirty[i]) first_dirty = DW'(i);
  end
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = vblank && |dirty ? SCAN : IDLE;
    else if (state == SCAN) state_n = WRITE;
    else state_n = idx == IW'(DIGITS - 1) ? IDLE : WRITE;
  end
  always_ff @(posedge vclock) begin
    if (!reset || clear) begin
      for (int i = 0; i < NUM_DRUMS; i++) cnt[i] <= '0;
      dirty <= '1;
    end else begin
      if (hit_ok) cnt[hd] <= inc_val;
      dirty <= (dirty & ~scan_clr) | hit_set;
    end
  end
  always_ff @(posedge vclock) begin
    if (!reset) begin
      state    <= IDLE;
      cur_drum <= '0;
      idx      <= '0;
      write    <= 1'b0;
      num      <= '0;
      blob     <= '0;
    end else begin
      state <= state_n;
      write <= state_n == WRITE;
      if (state_n == WRITE) begin
        cur_drum <= wr_drum;
        idx      <= wr_idx;
        num      <= wr_digit;
        blob     <= 4'(32'(wr_drum) * DIGITS + 32'(wr_idx));
      end
    end
  end
endmodule
